// File: rtl/act_feeder.sv
// Activation feeder: holds a DEPTH-entry activation buffer, streams it to the
// linear engine on request, captures the engine result and aborts on timeout.
module act_feeder #(
  parameter int DEPTH   = 20,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [4:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic [4:0]  row_sel,
  input  logic        start,
  output logic        busy,
  output logic        linear_en,
  input  logic        input_req,
  output logic [31:0] input_data,
  output logic [9:0]  input_addr,
  input  logic        output_valid,
  input  logic [31:0] output_data,
  input  logic [9:0]  output_addr,
  output logic        result_valid,
  output logic [31:0] result_data,
  output logic [9:0]  result_addr,
  output logic        done,
  output logic        err
);

  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [4:0]      LAST_IDX = 5'(DEPTH - 1);
  localparam logic [5:0]      DEPTH_W  = 6'(DEPTH);
  localparam logic [CW-1:0]   TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, ARM, FEED, DONE} state_t;

  state_t        state_r, state_s;
  logic [31:0]   act_buf_r [DEPTH];
  logic [4:0]    row_r, row_s;
  logic [4:0]    idx_r, idx_s, nidx_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          busy_r, busy_s;
  logic          linear_en_r, linear_en_s;
  logic          result_valid_r, result_valid_s;
  logic          done_r, done_s;
  logic          err_r, err_s;
  logic [31:0]   input_data_r, input_data_s;
  logic [9:0]    input_addr_r, input_addr_s;
  logic [31:0]   result_data_r, result_data_s;
  logic [9:0]    result_addr_r, result_addr_s;
  logic          wr_en_s;

  // Host writes land only while idle, in range, and not racing an accepted start.
  always_comb begin
    wr_en_s = (state_r == IDLE) && load_en && !start && ({1'b0, load_addr} < DEPTH_W);
  end

  // Activation buffer storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        act_buf_r[i] <= 32'h0;
      end
    end else if (wr_en_s) begin
      act_buf_r[load_addr] <= load_data;
    end else begin
      act_buf_r <= act_buf_r;
    end
  end

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_s        = state_r;
    row_s          = row_r;
    idx_s          = idx_r;
    cnt_s          = cnt_r;
    busy_s         = busy_r;
    linear_en_s    = 1'b0;
    result_valid_s = 1'b0;
    done_s         = 1'b0;
    err_s          = 1'b0;
    input_data_s   = input_data_r;
    input_addr_s   = input_addr_r;
    result_data_s  = result_data_r;
    result_addr_s  = result_addr_r;
    nidx_s         = (idx_r == LAST_IDX) ? idx_r : idx_r + 5'd1;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s      = ARM;
          busy_s       = 1'b1;
          linear_en_s  = 1'b1;
          row_s        = row_sel;
          idx_s        = 5'd0;
          cnt_s        = '0;
          input_data_s = act_buf_r[5'd0];
          input_addr_s = {row_sel, 5'd0};
        end else begin
          busy_s = 1'b0;
        end
      end
      ARM: begin
        state_s = FEED;
        cnt_s   = cnt_r + CNT_ONE;
      end
      FEED: begin
        cnt_s = cnt_r + CNT_ONE;
        if (input_req) begin
          idx_s        = nidx_s;
          input_data_s = act_buf_r[nidx_s];
          input_addr_s = {row_r, nidx_s};
        end else begin
          idx_s = idx_r;
        end
        // A result arriving on the timeout cycle still completes the pass.
        if (output_valid) begin
          state_s        = DONE;
          result_valid_s = 1'b1;
          done_s         = 1'b1;
          result_data_s  = output_data;
          result_addr_s  = output_addr;
        end else if (cnt_r == TO_LAST) begin
          state_s = IDLE;
          busy_s  = 1'b0;
          err_s   = 1'b1;
        end else begin
          state_s = FEED;
        end
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      row_r          <= 5'd0;
      idx_r          <= 5'd0;
      cnt_r          <= '0;
      busy_r         <= 1'b0;
      linear_en_r    <= 1'b0;
      result_valid_r <= 1'b0;
      done_r         <= 1'b0;
      err_r          <= 1'b0;
      input_data_r   <= 32'h0;
      input_addr_r   <= 10'h0;
      result_data_r  <= 32'h0;
      result_addr_r  <= 10'h0;
    end else begin
      state_r        <= state_s;
      row_r          <= row_s;
      idx_r          <= idx_s;
      cnt_r          <= cnt_s;
      busy_r         <= busy_s;
      linear_en_r    <= linear_en_s;
      result_valid_r <= result_valid_s;
      done_r         <= done_s;
      err_r          <= err_s;
      input_data_r   <= input_data_s;
      input_addr_r   <= input_addr_s;
      result_data_r  <= result_data_s;
      result_addr_r  <= result_addr_s;
    end
  end

  assign busy         = busy_r;
  assign linear_en    = linear_en_r;
  assign result_valid = result_valid_r;
  assign done         = done_r;
  assign err          = err_r;
  assign input_data   = input_data_r;
  assign input_addr   = input_addr_r;
  assign result_data  = result_data_r;
  assign result_addr  = result_addr_r;

endmodule

// File: tb/tb_act_feeder.sv
// Directed bench for act_feeder with a queue scoreboard for the element
// stream and the captured result.
module tb_act_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = 5'd0;
  logic [31:0] load_data = 32'h0;
  logic [4:0]  row_sel = 5'd0;
  logic        start = 1'b0;
  logic        busy, linear_en, result_valid, done, err;
  logic        input_req = 1'b0;
  logic [31:0] input_data, result_data;
  logic [9:0]  input_addr, result_addr;
  logic        output_valid = 1'b0;
  logic [31:0] output_data = 32'h0;
  logic [9:0]  output_addr = 10'h0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [9:0]  addr;
  } exp_t;

  exp_t feed_q[$];
  exp_t res_q[$];

  act_feeder #(.DEPTH(20), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .row_sel(row_sel), .start(start), .busy(busy), .linear_en(linear_en),
    .input_req(input_req), .input_data(input_data), .input_addr(input_addr),
    .output_valid(output_valid), .output_data(output_data), .output_addr(output_addr),
    .result_valid(result_valid), .result_data(result_data), .result_addr(result_addr),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic pop_feed(input string tag);
    exp_t e;
    e = feed_q.pop_front();
    chk({tag, "_data"}, input_data, e.data);
    chk({tag, "_addr"}, {22'd0, input_addr}, {22'd0, e.addr});
  endtask

  task automatic pop_result(input string tag);
    exp_t e;
    e = res_q.pop_front();
    chk({tag, "_data"}, result_data, e.data);
    chk({tag, "_addr"}, {22'd0, result_addr}, {22'd0, e.addr});
  endtask

  // One-cycle pulse outputs must never stay high two cycles running.
  logic prev_le = 1'b0, prev_rv = 1'b0, prev_dn = 1'b0, prev_er = 1'b0;
  always @(negedge clk) begin
    if (prev_le || prev_rv || prev_dn || prev_er) begin
      chk("pulse_width", {28'd0, prev_le & linear_en, prev_rv & result_valid,
                          prev_dn & done, prev_er & err}, 32'd0);
    end
    prev_le = linear_en;
    prev_rv = result_valid;
    prev_dn = done;
    prev_er = err;
  end

  logic saw_bad;

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_flags", {27'd0, busy, linear_en, result_valid, done, err}, 32'd0);
    chk("rst_in_data", input_data, 32'h0);
    chk("rst_in_addr", {22'd0, input_addr}, 32'd0);
    chk("rst_res_data", result_data, 32'h0);
    chk("rst_res_addr", {22'd0, result_addr}, 32'd0);

    // Load buf[k] = k+1, then out-of-range writes that must be dropped
    for (int k = 0; k < 20; k++) begin
      load_en = 1'b1; load_addr = 5'(k); load_data = 32'(k + 1);
      tick();
    end
    load_addr = 5'd20; load_data = 32'hDEAD_0014;
    tick();
    load_addr = 5'd31; load_data = 32'hDEAD_001F;
    tick();
    load_en = 1'b0;

    // Pass 1: stream every element, then capture a result
    row_sel = 5'd3; start = 1'b1;
    feed_q.push_back('{32'd1, 10'h060});
    tick();
    start = 1'b0;
    chk("arm_linear_en", {31'd0, linear_en}, 32'd1);
    chk("arm_busy", {31'd0, busy}, 32'd1);
    pop_feed("arm");
    tick();
    chk("feed_linear_en_low", {31'd0, linear_en}, 32'd0);
    input_req = 1'b1;
    for (int k = 1; k < 20; k++) begin
      feed_q.push_back('{32'(k + 1), {5'd3, 5'(k)}});
      tick();
      pop_feed("feed");
    end
    chk("feed_last_addr", {22'd0, input_addr}, 32'h073);
    for (int k = 0; k < 3; k++) begin
      feed_q.push_back('{32'd20, 10'h073});
      tick();
      pop_feed("saturate");
    end
    input_req = 1'b0;
    feed_q.push_back('{32'd20, 10'h073});
    tick();
    pop_feed("hold");
    load_en = 1'b1; load_addr = 5'd0; load_data = 32'hBAD0_0000;
    tick();
    load_en = 1'b0;
    output_valid = 1'b1; output_data = 32'h0123_4567; output_addr = 10'h07F;
    res_q.push_back('{32'h0123_4567, 10'h07F});
    tick();
    output_valid = 1'b0;
    chk("done_flags", {29'd0, result_valid, done, busy}, 32'd7);
    pop_result("result");
    tick();
    chk("after_done", {29'd0, result_valid, done, busy}, 32'd0);

    // Pass 2: engine silent -> timeout 64 cycles after linear_en
    row_sel = 5'd5; start = 1'b1;
    feed_q.push_back('{32'd1, 10'h0A0});
    tick();
    start = 1'b0;
    chk("t_linear_en", {31'd0, linear_en}, 32'd1);
    pop_feed("t_arm");
    saw_bad = 1'b0;
    for (int c = 1; c < 64; c++) begin
      tick();
      if (err || result_valid || !busy) saw_bad = 1'b1;
    end
    chk("t_no_early_err", {31'd0, saw_bad}, 32'd0);
    tick();
    chk("t_err", {31'd0, err}, 32'd1);
    chk("t_no_result", {31'd0, result_valid}, 32'd0);
    tick();
    chk("t_after", {29'd0, err, busy, result_valid}, 32'd0);
    output_valid = 1'b1; output_data = 32'hFFFF_FFFF; output_addr = 10'h3FF;
    res_q.push_back('{32'h0123_4567, 10'h07F});
    tick();
    output_valid = 1'b0;
    chk("idle_ov_ignored", {31'd0, result_valid}, 32'd0);
    pop_result("result_hold");

    // Pass 3: reset mid-FEED
    row_sel = 5'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    input_req = 1'b1;
    tick();
    input_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_flags", {27'd0, busy, linear_en, result_valid, done, err}, 32'd0);
    chk("mid_rst_in", {input_data[21:0], input_addr}, 32'd0);
    chk("mid_rst_res", result_data, 32'h0);
    tick();
    chk("mid_rst_quiet", {29'd0, done, err, result_valid}, 32'd0);

    // Pass 4: cleared buffer, result on the timeout cycle wins
    row_sel = 5'd2; start = 1'b1;
    feed_q.push_back('{32'h0, 10'h040});
    tick();
    start = 1'b0;
    pop_feed("cleared_arm");
    for (int c = 1; c < 64; c++) begin
      tick();
    end
    output_valid = 1'b1; output_data = 32'hA5A5_0001; output_addr = 10'h155;
    res_q.push_back('{32'hA5A5_0001, 10'h155});
    tick();
    output_valid = 1'b0;
    chk("race_flags", {29'd0, result_valid, done, err}, 32'd6);
    pop_result("race_result");
    tick();
    chk("race_after", {29'd0, busy, err, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_feeder.md
ACT_FEEDER -- requirements
Module: act_feeder

Interface
REQ-001 Parameter DEPTH, default 20, is the number of 32-bit activation elements per linear pass.
REQ-002 Parameter TIMEOUT, default 64, is the maximum cycles from linear_en to output_valid before abort.
REQ-003 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load_en  input  1  host write strobe into the activation buffer.
REQ-006 load_addr  input  5  buffer element index for the host write.
REQ-007 load_data  input  32  activation value, signed 1.7.24 fixed point.
REQ-008 row_sel  input  5  weight row index, sampled on accepted start.
REQ-009 start  input  1  request one linear pass.
REQ-010 busy  output  1  high from accepted start until return to IDLE.
REQ-011 linear_en  output  1  one-cycle enable pulse to the linear engine.
REQ-012 input_req  input  1  engine request for the next activation element.
REQ-013 input_data  output  32  activation element presented to the engine.
REQ-014 input_addr  output  10  {row_sel latched, element index[4:0]} presented with input_data.
REQ-015 output_valid  input  1  engine result strobe.
REQ-016 output_data  input  32  engine result value.
REQ-017 output_addr  input  10  engine result address.
REQ-018 result_valid  output  1  one-cycle pulse, captured result available.
REQ-019 result_data  output  32  captured output_data.
REQ-020 result_addr  output  10  captured output_addr.
REQ-021 done  output  1  one-cycle pulse on successful pass completion.
REQ-022 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-023 Buffer SHALL be DEPTH x 32 registers; in IDLE, load_en with load_addr < DEPTH writes load_data at the clock edge.
REQ-024 Writes with load_addr >= DEPTH, writes while busy, and writes in the same cycle as an accepted start SHALL be dropped.
REQ-025 States SHALL be IDLE, ARM, FEED, DONE; encoding is free.
REQ-026 IDLE: start=1 SHALL latch row_sel, clear element index and timeout counter, go to ARM; start outside IDLE SHALL be ignored.
REQ-027 ARM (one cycle): linear_en=1, input_data=buf[0], input_addr={row,5'd0}, busy=1; next state FEED.
REQ-028 FEED: each cycle with input_req=1 SHALL increment the element index (saturating at DEPTH-1) and register input_data=buf[index], input_addr={row,index} for the following cycle.
REQ-029 input_data/input_addr SHALL hold their value in cycles with input_req=0.
REQ-030 Timeout counter SHALL count cycles from ARM; reaching TIMEOUT in FEED without output_valid SHALL pulse err for one cycle and return to IDLE.
REQ-031 output_valid=1 in FEED SHALL capture output_data/output_addr into result_data/result_addr and go to DONE; output_valid outside FEED SHALL be ignored.
REQ-032 DONE (one cycle): result_valid=1, done=1, busy=1; next state IDLE.
REQ-033 output_valid and timeout in the same cycle: output_valid wins, no err.
REQ-034 result_data/result_addr SHALL hold until the next capture.
REQ-035 linear_en, result_valid, done, err SHALL never be high for more than one consecutive cycle.

Reset
REQ-036 rst=1 SHALL force IDLE and drive busy, linear_en, result_valid, done, err to 0, input_data/result_data to 32'h0, input_addr/result_addr to 10'h0, clear index and timeout counter.
REQ-037 Reset SHALL clear all buffer entries to 32'h0.
REQ-038 rst asserted mid-pass SHALL abort immediately with no done, err, or result_valid pulse.

Verification
REQ-039 Load buf[k]=k+1 (k=0..19), row_sel=3, start -> next cycle linear_en=1, input_data=1, input_addr=10'h060; after 19 input_req pulses input_data=20, input_addr=10'h073.
REQ-040 During FEED, output_valid with output_data=32'h0123_4567, output_addr=10'h07F -> next cycle result_valid=1, done=1, result_data=32'h0123_4567, result_addr=10'h07F, then busy=0.
REQ-041 Start with engine never asserting output_valid -> err=1 for one cycle exactly 64 cycles after linear_en, busy=0 after, result_valid never high.
REQ-042 load_en with load_addr=20 and load_en while busy -> buffer unchanged (read back via a subsequent pass).
REQ-043 More than 19 input_req pulses -> index saturates, input_addr stays {row,5'd19}.
REQ-044 rst pulsed mid-FEED -> all outputs at reset values next cycle, no done/err; new start afterward presents input_data=32'h0 for element 0.
